// File: rtl/nios1_nios2_qsys_0_oci_pkg.sv
// Shared constants and state type for the OCI trace atom packer.
package nios1_nios2_qsys_0_oci_pkg;

  localparam int DCT_ATOM_W = 2;
  localparam int DCT_DEPTH  = 15;
  localparam int DCT_WORD_W = DCT_ATOM_W * DCT_DEPTH;
  localparam int DCT_CNT_W  = $clog2(DCT_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } dct_state_e;

endpackage

// File: rtl/nios1_nios2_qsys_0_oci_dct_outreg.sv
// Output word register of the trace packer: holds one packed word until the
// consumer takes it with out_ready.
module nios1_nios2_qsys_0_oci_dct_outreg
  import nios1_nios2_qsys_0_oci_pkg::*;
#(
  parameter int WORD_W = DCT_WORD_W,
  parameter int CNT_W  = DCT_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_cnt   <= load_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios1_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit words with flush/test-ending support.
// Optional macro NIOS1_OCI_DCT_OVF_EN: never backpressure, count dropped atoms in ovf_cnt.
module nios1_nios2_qsys_0_oci_dct_packer
  import nios1_nios2_qsys_0_oci_pkg::*;
#(
  parameter int ATOM_W = DCT_ATOM_W,
  parameter int DEPTH  = DCT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         atm_valid,
  input  logic [ATOM_W-1:0]            atm,
  output logic                         atm_ready,
  input  logic                         flush,
  input  logic                         test_ending,
  output logic [ATOM_W*DEPTH-1:0]      dct_buffer,
  output logic [$clog2(DEPTH+1)-1:0]   dct_count,
  output logic                         out_valid,
  output logic [ATOM_W*DEPTH-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0]   out_cnt,
  input  logic                         out_ready,
  output logic                         test_has_ended
`ifdef NIOS1_OCI_DCT_OVF_EN
  , output logic [7:0]                 ovf_cnt
`endif
);

  localparam int WORD_W = ATOM_W * DEPTH;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  dct_state_e        state, state_d;
  logic [WORD_W-1:0] buffer_d, load_data;
  logic [CNT_W-1:0]  count_d, load_cnt;
  logic              flush_pend, flush_pend_d;
  logic              ending_seen, ending_seen_d, ended_d;
  logic              out_free, blocked, accept, flush_req, load, out_valid_d;

`ifdef NIOS1_OCI_DCT_OVF_EN
  assign atm_ready = 1'b1;
`else
  assign atm_ready = (dct_count < CNT_FULL) || out_ready || !out_valid;
`endif

  assign out_free  = !out_valid || out_ready;
  assign blocked   = (state == ST_FULL) && !out_free;
  assign accept    = atm_valid && atm_ready && !blocked;
  assign flush_req = flush || test_ending || flush_pend;

  always_comb begin
    load_data = dct_buffer;
    load_cnt  = dct_count;
    load      = 1'b0;
    buffer_d  = dct_buffer;
    count_d   = dct_count;
    if (state == ST_FULL) begin
      // A full buffer drains whole; an atom taken in the same cycle starts the next word.
      load = out_free;
      if (load) begin
        buffer_d = accept ? WORD_W'(atm) : '0;
        count_d  = CNT_W'(accept);
      end
    end else begin
      if (accept) begin
        load_data = dct_buffer | (WORD_W'(atm) << (ATOM_W * int'(dct_count)));
        load_cnt  = dct_count + CNT_W'(1);
      end
      load     = out_free && ((load_cnt == CNT_FULL) || (flush_req && (load_cnt != '0)));
      buffer_d = load ? '0 : load_data;
      count_d  = load ? '0 : load_cnt;
    end
    flush_pend_d  = !load && flush_req && (count_d != '0);
    out_valid_d   = load || (out_valid && !out_ready);
    ending_seen_d = ending_seen || test_ending;
    ended_d       = test_has_ended || (ending_seen_d && (count_d == '0) && !out_valid_d);
    if (count_d == '0)          state_d = ST_EMPTY;
    else if (count_d == CNT_FULL) state_d = ST_FULL;
    else                        state_d = ST_FILL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_EMPTY;
      dct_buffer     <= '0;
      dct_count      <= '0;
      flush_pend     <= 1'b0;
      ending_seen    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_d;
      dct_buffer     <= buffer_d;
      dct_count      <= count_d;
      flush_pend     <= flush_pend_d;
      ending_seen    <= ending_seen_d;
      test_has_ended <= ended_d;
    end
  end

`ifdef NIOS1_OCI_DCT_OVF_EN
  // Atoms arriving while the full buffer cannot drain are lost; count them, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt <= '0;
    end else if (atm_valid && blocked && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

  nios1_nios2_qsys_0_oci_dct_outreg #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

endmodule

// File: tb/tb_nios1_nios2_qsys_0_oci_dct_packer.sv
// Directed, table-driven bench for the OCI trace atom packer.
module tb_nios1_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atm_valid = 1'b0;
  logic [1:0]  atm = 2'd0;
  logic        atm_ready;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        out_valid;
  logic [29:0] out_data;
  logic [3:0]  out_cnt;
  logic        out_ready = 1'b1;
  logic        test_has_ended;
`ifdef NIOS1_OCI_DCT_OVF_EN
  logic [7:0]  ovf_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios1_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atm_valid      (atm_valid),
    .atm            (atm),
    .atm_ready      (atm_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_cnt        (out_cnt),
    .out_ready      (out_ready),
    .test_has_ended (test_has_ended)
`ifdef NIOS1_OCI_DCT_OVF_EN
    , .ovf_cnt      (ovf_cnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  a;
    logic        f;
    logic        te;
    logic        ordy;
    logic        exp_rdy;
    logic [3:0]  exp_count;
    logic [29:0] exp_buf;
    logic        exp_ov;
    logic [29:0] exp_od;
    logic [3:0]  exp_oc;
  } vec_t;

  vec_t vecs[15];

  task automatic applyStimulus(input logic v, input logic [1:0] a, input logic f,
                               input logic te, input logic ordy);
    atm_valid   = v;
    atm         = a;
    flush       = f;
    test_ending = te;
    out_ready   = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 30'h3,  1'b0, 30'h24E4E4E4, 4'd15};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 30'h3,  1'b0, 30'h24E4E4E4, 4'd15};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 30'h23, 1'b0, 30'h24E4E4E4, 4'd15};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b1, 30'h23, 4'd3};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 30'h23, 4'd3};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 30'h23, 4'd3};
    vecs[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b1, 30'h1,  4'd1};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 30'h2,  1'b1, 30'h1,  4'd1};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 30'h2,  1'b1, 30'h1,  4'd1};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b1, 30'h2,  4'd1};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 30'h2,  4'd1};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 30'h3,  1'b0, 30'h2,  4'd1};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 30'h7,  1'b0, 30'h2,  4'd1};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b1, 30'h7,  4'd2};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 30'h7,  4'd2};

    // Reset state
    tick();
    checkOutput("rst_count", 32'(dct_count), 32'd0);
    checkOutput("rst_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_cnt", 32'(out_cnt), 32'd0);
    checkOutput("rst_ended", 32'(test_has_ended), 32'd0);
    checkOutput("rst_atm_ready", 32'(atm_ready), 32'd1);
    reset_n = 1'b1;

    // Fifteen atoms 0,1,2,3,... fill one word
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
      tick();
      if (i == 13) begin
        checkOutput("fill14_count", 32'(dct_count), 32'd14);
        checkOutput("fill14_buffer", 32'(dct_buffer), 32'h04E4E4E4);
        checkOutput("fill14_out_valid", 32'(out_valid), 32'd0);
      end
    end
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_out_cnt", 32'(out_cnt), 32'd15);
    checkOutput("full_out_data", 32'(out_data), 32'h24E4E4E4);
    checkOutput("full_count", 32'(dct_count), 32'd0);
    checkOutput("full_buffer", 32'(dct_buffer), 32'd0);
    idle();
    tick();
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

    // Table of single-cycle vectors: flush, partial words, sticky flush under backpressure
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].a, vecs[i].f, vecs[i].te, vecs[i].ordy);
      #1;
      checkOutput($sformatf("vec%0d_atm_ready", i), 32'(atm_ready), 32'(vecs[i].exp_rdy));
      tick();
      checkOutput($sformatf("vec%0d_count", i), 32'(dct_count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_buffer", i), 32'(dct_buffer), 32'(vecs[i].exp_buf));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
      checkOutput($sformatf("vec%0d_out_cnt", i), 32'(out_cnt), 32'(vecs[i].exp_oc));
    end

    // Backpressure: 30 atoms with the consumer stalled
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, (i < 15) ? 2'd1 : 2'd2, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("bp%0d_atm_ready", i), 32'(atm_ready), 32'd1);
      tick();
    end
    checkOutput("bp_atm_ready_full", 32'(atm_ready), 32'd0);
    checkOutput("bp_count", 32'(dct_count), 32'd15);
    checkOutput("bp_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    checkOutput("bp_out_data", 32'(out_data), 32'h15555555);
    checkOutput("bp_out_cnt", 32'(out_cnt), 32'd15);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold_out_data", 32'(out_data), 32'h15555555);
    checkOutput("bp_hold_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_count", 32'(dct_count), 32'd15);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("bp_release_atm_ready", 32'(atm_ready), 32'd1);
    tick();
    checkOutput("bp2_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp2_out_data", 32'(out_data), 32'h2AAAAAAA);
    checkOutput("bp2_out_cnt", 32'(out_cnt), 32'd15);
    checkOutput("bp2_count", 32'(dct_count), 32'd1);
    checkOutput("bp2_buffer", 32'(dct_buffer), 32'd3);
    idle();
    tick();
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("bp3_out_data", 32'(out_data), 32'd3);
    checkOutput("bp3_out_cnt", 32'(out_cnt), 32'd1);
    idle();
    tick();

    // Asynchronous reset in the middle of a packet
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle();
    checkOutput("pre_rst_count", 32'(dct_count), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_count", 32'(dct_count), 32'd0);
    checkOutput("arst_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("arst_out_data", 32'(out_data), 32'd0);
    checkOutput("arst_out_cnt", 32'(out_cnt), 32'd0);
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    #1;
    reset_n = 1'b1;
    tick();

    // test_ending with five atoms pending
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("te_out_valid", 32'(out_valid), 32'd1);
    checkOutput("te_out_cnt", 32'(out_cnt), 32'd5);
    checkOutput("te_out_data", 32'(out_data), 32'h155);
    checkOutput("te_ended_early", 32'(test_has_ended), 32'd0);
    tick();
    checkOutput("te_ended", 32'(test_has_ended), 32'd1);
    checkOutput("te_out_valid_clr", 32'(out_valid), 32'd0);
    idle();
    tick();
    checkOutput("te_ended_sticky", 32'(test_has_ended), 32'd1);

`ifdef NIOS1_OCI_DCT_OVF_EN
    // Overflow counting with the consumer stalled
    #2;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("ovf%0d_atm_ready", i), 32'(atm_ready), 32'd1);
      tick();
    end
    checkOutput("ovf_cnt", 32'(ovf_cnt), 32'd10);
    idle();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
